fifo_stream_reader: RTL



---
 rtl/fifo_stream_reader.sv | 102 ++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side adapter: drains a FIFO through rd_req/q/empty and presents the words
// as a registered valid/ready stream, hiding the FIFO read latency with a 2-entry buffer.
module fifo_stream_reader #(
  parameter int unsigned DWIDTH    = 8,
  parameter string       SHOWAHEAD = "OFF",
  parameter int unsigned CWIDTH    = 16
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  output logic              fifo_rd_req_o,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic [1:0]        buf_level_o,
  output logic [CWIDTH-1:0] words_o
);

  localparam bit SHOW_ON = (SHOWAHEAD == "ON");

  logic [DWIDTH-1:0] head_q, head_d;
  logic [DWIDTH-1:0] tail_q, tail_d;
  logic [1:0]        occ_q, occ_d;
  logic              valid_q, valid_d;
  logic              inflight_q, inflight_d;
  logic [CWIDTH-1:0] words_q, words_d;

  logic       pop;
  logic       cap;
  logic       rd_req;
  logic [2:0] pending;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    pop        = valid_q & src_ready_i;
    // Words that will occupy the buffer at the end of this cycle if no new request is made.
    pending    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    // Held off during reset so the FIFO does not advance past words that are being discarded.
    rd_req     = srst_n_i & ~fifo_empty_i & (pending < 3'd2);
    cap        = SHOW_ON ? rd_req : inflight_q;
    inflight_d = SHOW_ON ? 1'b0 : rd_req;
    words_d    = words_q + {{(CWIDTH-1){1'b0}}, pop};

    unique case ({cap, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = fifo_q_i;
        else               tail_d = fifo_q_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the incoming word goes behind whatever is left after the pop.
        if (occ_q == 2'd1) begin
          head_d = fifo_q_i;
        end else begin
          head_d = tail_q;
          tail_d = fifo_q_i;
        end
      end
      default: ;
    endcase

    valid_d = (occ_d != 2'd0);
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!srst_n_i) begin
      // NOTE: the two data entries are reset too because src_data_o must read 0 after reset.
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= 2'd0;
      valid_q    <= 1'b0;
      inflight_q <= 1'b0;
      words_q    <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      valid_q    <= valid_d;
      inflight_q <= inflight_d;
      words_q    <= words_d;
    end
  end

  assign fifo_rd_req_o = rd_req;
  assign src_data_o    = head_q;
  assign src_valid_o   = valid_q;
  assign buf_level_o   = occ_q;
  assign words_o       = words_q;

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!srst_n_i)
    (({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2));

endmodule
